isp_frame_arbiter: RTL and testbench

Frame-granular arbiter sharing one single-channel pixel stage (RGB565 in, RGB565 out, `dataEn`/`outEn` strobes, fixed latency) between two frame sources. Typical sources are the sensor path and a test-pattern/readback path. Grant is held for a whole frame and re-arbitrated only at frame boundaries. Stage results are routed back to the owning requester through a tag pipeline. Sits directly in front of, and behind, the shared stage in the ISP chain.

---
 rtl/isp_frame_arbiter_pkg.sv | 24 ++
 rtl/isp_frame_arbiter_if.sv | 54 +++++
 rtl/isp_tag_pipe.sv | 46 ++++
 rtl/isp_frame_arbiter.sv | 152 +++++++++++++++
 tb/tb_isp_frame_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isp_frame_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// isp_frame_arbiter_pkg
// Shared ISP types for the frame arbiter and its tag pipeline.
//   DW_DEFAULT  : default pixel width (RGB565)
//   arb_state_t : arbiter FSM state (IDLE / GRANT0 / GRANT1)
//   tag_t       : per-pixel routing tag {valid, id, last}
// ---------------------------------------------------------------------------
package isp_frame_arbiter_pkg;

    localparam int unsigned DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } tag_t;

endpackage

// File: rtl/isp_frame_arbiter_if.sv
// ---------------------------------------------------------------------------
// isp_frame_arbiter_if
// Bundles the two requester pixel streams, the shared-stage drive/return
// signals and the per-requester result streams.
//   slave  : arbiter side (takes requests, drives the stage, returns results)
//   master : environment side (requesters, stage, result consumers)
// ---------------------------------------------------------------------------
interface isp_frame_arbiter_if
    import isp_frame_arbiter_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
);
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_last;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_last;
    logic          req1_ready;

    logic [DW-1:0] st_din;
    logic          st_en;
    logic [DW-1:0] st_dout;
    logic          st_out_en;

    logic [DW-1:0] out0_data;
    logic          out0_en;
    logic          frame_done0;
    logic [DW-1:0] out1_data;
    logic          out1_en;
    logic          frame_done1;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        output req0_ready, req1_ready,
        output st_din, st_en,
        input  st_dout, st_out_en,
        output out0_data, out0_en, frame_done0,
        output out1_data, out1_en, frame_done1
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        input  req0_ready, req1_ready,
        input  st_din, st_en,
        output st_dout, st_out_en,
        input  out0_data, out0_en, frame_done0,
        input  out1_data, out1_en, frame_done1
    );

endinterface

// File: rtl/isp_tag_pipe.sv
// ---------------------------------------------------------------------------
// isp_tag_pipe
// STAGE_LAT-deep shift register of routing tags, used to follow pixels
// through a fixed-latency shared stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   tag_in     : tag entering alongside the stage input strobe
//   tag_out    : tag aligned with the stage output strobe
//   any_valid  : some stage of the pipe holds a valid tag
// ---------------------------------------------------------------------------
module isp_tag_pipe
    import isp_frame_arbiter_pkg::*;
#(
    parameter int unsigned STAGE_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t pipe [STAGE_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGE_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= tag_in;
            for (int unsigned i = 1; i < STAGE_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tag_out = pipe[STAGE_LAT-1];

    always_comb begin
        any_valid = 1'b0;
        for (int unsigned i = 0; i < STAGE_LAT; i++) begin
            any_valid = any_valid | pipe[i].valid;
        end
    end

endmodule

// File: rtl/isp_frame_arbiter.sv
// ---------------------------------------------------------------------------
// isp_frame_arbiter
// Shares one fixed-latency pixel stage between two frame sources. The grant
// is held for a whole frame; results are steered back to the owner through
// a tag pipeline that tracks the stage latency.
//   clk, rst_n    : clock, asynchronous active-low reset
//   cfg_en        : per-requester enable mask (sampled in IDLE only)
//   cfg_fixed_pri : 0 = round robin, 1 = requester 0 strict priority
//   bus           : requester streams, stage drive/return, result streams
//   busy          : grant held or results in flight
//   grant_id      : current / last owner
//   frame_cnt0/1  : completed-frame counters, present only when
//                   ISP_ARB_STATS_EN is defined
// ---------------------------------------------------------------------------
module isp_frame_arbiter
    import isp_frame_arbiter_pkg::*;
#(
    parameter int unsigned STAGE_LAT = 1,
    parameter int unsigned DW        = DW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cfg_en,
    input  logic                cfg_fixed_pri,
    isp_frame_arbiter_if.slave  bus,
    output logic                busy,
    output logic                grant_id
`ifdef ISP_ARB_STATS_EN
    ,
    output logic [15:0]         frame_cnt0,
    output logic [15:0]         frame_cnt1
`endif
);

    arb_state_t    state;
    logic          last_winner;
    logic          ready0;
    logic          ready1;
    logic          st_en_q;
    logic [DW-1:0] st_din_q;
    tag_t          stage_tag;
    tag_t          tag_out;
    logic          pipe_busy;

    logic xfer0, xfer1;
    logic elig0, elig1;
    logic pick0;
    logic out0_en, out1_en;
    logic done0, done1;

    assign xfer0 = bus.req0_valid & ready0;
    assign xfer1 = bus.req1_valid & ready1;
    assign elig0 = bus.req0_valid & cfg_en[0];
    assign elig1 = bus.req1_valid & cfg_en[1];
    // On a round-robin tie the requester opposite the last winner goes next.
    assign pick0 = elig0 & (cfg_fixed_pri | ~elig1 | last_winner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            ready0      <= 1'b0;
            ready1      <= 1'b0;
            grant_id    <= 1'b0;
            st_en_q     <= 1'b0;
            st_din_q    <= '0;
            stage_tag   <= '0;
        end else begin
            st_en_q         <= xfer0 | xfer1;
            st_din_q        <= xfer0 ? bus.req0_data : (xfer1 ? bus.req1_data : '0);
            stage_tag.valid <= xfer0 | xfer1;
            stage_tag.id    <= xfer1;
            // Only the owner's last is honoured, since only the owner transfers.
            stage_tag.last  <= (xfer0 & bus.req0_last) | (xfer1 & bus.req1_last);

            case (state)
                IDLE: begin
                    if (pick0) begin
                        state    <= GRANT0;
                        ready0   <= 1'b1;
                        grant_id <= 1'b0;
                    end else if (elig1) begin
                        state    <= GRANT1;
                        ready1   <= 1'b1;
                        grant_id <= 1'b1;
                    end
                end
                GRANT0: begin
                    if (xfer0 && bus.req0_last) begin
                        state       <= IDLE;
                        ready0      <= 1'b0;
                        last_winner <= 1'b0;
                    end
                end
                GRANT1: begin
                    if (xfer1 && bus.req1_last) begin
                        state       <= IDLE;
                        ready1      <= 1'b0;
                        last_winner <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ready0 <= 1'b0;
                    ready1 <= 1'b0;
                end
            endcase
        end
    end

    // stage_tag is the tag stage aligned with st_en; the pipe adds STAGE_LAT.
    isp_tag_pipe #(
        .STAGE_LAT (STAGE_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_in    (stage_tag),
        .tag_out   (tag_out),
        .any_valid (pipe_busy)
    );

    assign out0_en = bus.st_out_en & tag_out.valid & ~tag_out.id;
    assign out1_en = bus.st_out_en & tag_out.valid &  tag_out.id;
    assign done0   = out0_en & tag_out.last;
    assign done1   = out1_en & tag_out.last;

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.st_en       = st_en_q;
    assign bus.st_din      = st_din_q;
    assign bus.out0_en     = out0_en;
    assign bus.out1_en     = out1_en;
    assign bus.out0_data   = out0_en ? bus.st_dout : '0;
    assign bus.out1_data   = out1_en ? bus.st_dout : '0;
    assign bus.frame_done0 = done0;
    assign bus.frame_done1 = done1;

    assign busy = (state != IDLE) | stage_tag.valid | pipe_busy;

`ifdef ISP_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
        end else begin
            if (done0) frame_cnt0 <= frame_cnt0 + 16'd1;
            if (done1) frame_cnt1 <= frame_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_isp_frame_arbiter.sv
module tb_isp_frame_arbiter;

    localparam int unsigned STAGE_LAT = 1;
    localparam logic [15:0] KEY = 16'h5A5A;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cfg_en = 2'b11;
    logic       cfg_fixed_pri = 1'b0;
    logic       busy;
    logic       grant_id;
`ifdef ISP_ARB_STATS_EN
    logic [15:0] frame_cnt0;
    logic [15:0] frame_cnt1;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    isp_frame_arbiter_if #(.DW(16)) bus ();

    isp_frame_arbiter #(
        .STAGE_LAT (STAGE_LAT),
        .DW        (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_en        (cfg_en),
        .cfg_fixed_pri (cfg_fixed_pri),
        .bus           (bus),
        .busy          (busy),
        .grant_id      (grant_id)
`ifdef ISP_ARB_STATS_EN
        ,
        .frame_cnt0    (frame_cnt0),
        .frame_cnt1    (frame_cnt1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stage model: fixed latency, result = pixel ^ KEY.
    logic        sen  [STAGE_LAT];
    logic [15:0] sdat [STAGE_LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGE_LAT; i++) begin
                sen[i]  <= 1'b0;
                sdat[i] <= '0;
            end
        end else begin
            sen[0]  <= bus.st_en;
            sdat[0] <= bus.st_din ^ KEY;
            for (int i = 1; i < STAGE_LAT; i++) begin
                sen[i]  <= sen[i-1];
                sdat[i] <= sdat[i-1];
            end
        end
    end
    assign bus.st_out_en = sen[STAGE_LAT-1];
    assign bus.st_dout   = sdat[STAGE_LAT-1];

    // Scoreboard: pop and compare each result as it leaves the stage.
    always @(negedge clk) begin
        exp_t e;
        if (bus.out0_en === 1'b1) begin
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $display("FAIL out0_unexpected: got data %h done %b at cycle %0d, required no output",
                         bus.out0_data, bus.frame_done0, cyc);
            end else begin
                e = q0.pop_front();
                if (bus.out0_data !== e.data || bus.frame_done0 !== e.last || cyc !== e.cyc) begin
                    miscompares++;
                    $display("FAIL out0_result: got data %h done %b cycle %0d, required data %h done %b cycle %0d",
                             bus.out0_data, bus.frame_done0, cyc, e.data, e.last, e.cyc);
                end
            end
        end else begin
            vectors++;
            if (bus.out0_data !== 16'h0 || bus.frame_done0 !== 1'b0) begin
                miscompares++;
                $display("FAIL out0_idle: got data %h done %b with en %b, required 0 0",
                         bus.out0_data, bus.frame_done0, bus.out0_en);
            end
        end
        if (bus.out1_en === 1'b1) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL out1_unexpected: got data %h done %b at cycle %0d, required no output",
                         bus.out1_data, bus.frame_done1, cyc);
            end else begin
                e = q1.pop_front();
                if (bus.out1_data !== e.data || bus.frame_done1 !== e.last || cyc !== e.cyc) begin
                    miscompares++;
                    $display("FAIL out1_result: got data %h done %b cycle %0d, required data %h done %b cycle %0d",
                             bus.out1_data, bus.frame_done1, cyc, e.data, e.last, e.cyc);
                end
            end
        end else begin
            vectors++;
            if (bus.out1_data !== 16'h0 || bus.frame_done1 !== 1'b0) begin
                miscompares++;
                $display("FAIL out1_idle: got data %h done %b with en %b, required 0 0",
                         bus.out1_data, bus.frame_done1, bus.out1_en);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic v, input logic [15:0] d, input logic l);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
        end else begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        cfg_en = 2'b11;
        cfg_fixed_pri = 1'b0;
        repeat (2) tick();
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
    endtask

    // Sends an n-pixel frame (base + k*0x1111); optional valid gap of gap_len
    // cycles after pixel gap_after. Returns the cycle ready was first seen.
    task automatic send_frame(input int id, input int n, input logic [15:0] base,
                              input int gap_after, input int gap_len, output int gcyc);
        int k;
        int waited;
        int hold;
        logic rdy;
        logic [15:0] pix;
        k = 0; waited = 0; hold = 0; gcyc = -1;
        drive(id, 1'b1, base, n == 1);
        while (k < n) begin
            @(negedge clk);
            rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
            if (hold > 0) begin
                hold--;
                vectors++;
                if (rdy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL grant_hold_gap: req%0d ready %b at cycle %0d, required 1", id, rdy, cyc);
                end
            end else if (rdy === 1'b1) begin
                if (gcyc < 0) gcyc = cyc;
                pix = base + 16'(k) * 16'h1111;
                if (id == 0) q0.push_back('{data: pix ^ KEY, last: (k == n - 1), cyc: cyc + 1 + STAGE_LAT});
                else         q1.push_back('{data: pix ^ KEY, last: (k == n - 1), cyc: cyc + 1 + STAGE_LAT});
                k++;
                if (k - 1 == gap_after) hold = gap_len;
            end else begin
                waited++;
                if (waited > 40) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL grant_timeout: req%0d ready 0 after %0d cycles, required 1", id, waited);
                    drive(id, 1'b0, '0, 1'b0);
                    return;
                end
            end
            @(posedge clk);
            #1;
            if (k >= n) drive(id, 1'b0, '0, 1'b0);
            else        drive(id, hold == 0, base + 16'(k) * 16'h1111, k == n - 1);
        end
    endtask

    task automatic drain(input string name);
        repeat (STAGE_LAT + 4) tick();
        vectors++;
        if (q0.size() != 0 || q1.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain: got pending %0d/%0d busy %b, required 0/0 busy 0",
                     name, q0.size(), q1.size(), busy);
        end
    endtask

    task automatic test_reset();
        logic [56:0] obs;
        rst_n = 1'b0;
        cfg_en = 2'b11;
        cfg_fixed_pri = 1'b0;
        drive(0, 1'b1, 16'h1234, 1'b0);
        drive(1, 1'b1, 16'h5678, 1'b1);
        repeat (3) tick();
        obs = {bus.req0_ready, bus.req1_ready, bus.st_en, bus.st_din, bus.out0_en, bus.out0_data,
               bus.out1_en, bus.out1_data, bus.frame_done0, bus.frame_done1, busy, grant_id};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", obs);
        end
    endtask

    task automatic test_single();
        int c0, g0, first_en, n_en, n_r1;
        reset_dut();
        c0 = cyc; first_en = -1; n_en = 0; n_r1 = 0;
        fork
            send_frame(0, 4, 16'h1111, -1, 0, g0);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (bus.st_en === 1'b1) begin
                        if (first_en < 0) first_en = cyc;
                        n_en++;
                    end
                    if (bus.req1_ready === 1'b1) n_r1++;
                end
            end
        join
        vectors++;
        if (g0 !== c0 + 1) begin
            miscompares++;
            $display("FAIL single_grant: got ready0 at cycle %0d, required %0d", g0, c0 + 1);
        end
        vectors++;
        if (first_en !== c0 + 2 || n_en !== 4) begin
            miscompares++;
            $display("FAIL single_st_en: got first %0d count %0d, required first %0d count 4", first_en, n_en, c0 + 2);
        end
        vectors++;
        if (n_r1 !== 0) begin
            miscompares++;
            $display("FAIL single_ready1: got %0d cycles high, required 0", n_r1);
        end
        drain("single");
    endtask

    task automatic test_round_robin(input logic fixed);
        int c0, ga, gb, g1;
        int ea, eb, e1;
        reset_dut();
        cfg_fixed_pri = fixed;
        c0 = cyc;
        fork
            begin
                send_frame(0, 2, 16'h0A00, -1, 0, ga);
                send_frame(0, 2, 16'h0B00, -1, 0, gb);
            end
            send_frame(1, 2, 16'h1A00, -1, 0, g1);
        join
        ea = c0 + 1;
        eb = fixed ? c0 + 4 : c0 + 7;
        e1 = fixed ? c0 + 7 : c0 + 4;
        vectors++;
        if (ga !== ea || gb !== eb || g1 !== e1) begin
            miscompares++;
            $display("FAIL arb_order_fixed%0d: got grants %0d %0d %0d, required %0d %0d %0d",
                     fixed, ga, g1, gb, ea, e1, eb);
        end
        vectors++;
        if (grant_id !== fixed) begin
            miscompares++;
            $display("FAIL arb_grant_id_fixed%0d: got %b, required %b", fixed, grant_id, fixed);
        end
        drain("arb");
    endtask

    task automatic test_cfg_en();
        int c0, g1, n_r0;
        reset_dut();
        cfg_en = 2'b10;
        c0 = cyc; n_r0 = 0;
        drive(0, 1'b1, 16'hDEAD, 1'b1);
        fork
            send_frame(1, 4, 16'h2000, -1, 0, g1);
            begin
                repeat (2) tick();
                cfg_en = 2'b00;
            end
            begin
                repeat (8) begin
                    @(negedge clk);
                    if (bus.req0_ready === 1'b1) n_r0++;
                end
            end
        join
        vectors++;
        if (g1 !== c0 + 1) begin
            miscompares++;
            $display("FAIL cfg_en_grant1: got ready1 at cycle %0d, required %0d", g1, c0 + 1);
        end
        vectors++;
        if (n_r0 !== 0) begin
            miscompares++;
            $display("FAIL cfg_en_ready0: got %0d cycles high, required 0", n_r0);
        end
        drain("cfg_en");
        drive(0, 1'b0, '0, 1'b0);
        cfg_en = 2'b11;
    endtask

    task automatic test_gaps();
        int c0, g0, g1;
        reset_dut();
        c0 = cyc;
        fork
            send_frame(0, 4, 16'h3000, 0, 2, g0);
            send_frame(1, 1, 16'h4000, -1, 0, g1);
        join
        vectors++;
        if (g0 !== c0 + 1 || g1 !== c0 + 8) begin
            miscompares++;
            $display("FAIL gaps_order: got grants %0d %0d, required %0d %0d", g0, g1, c0 + 1, c0 + 8);
        end
        drain("gaps");
    endtask

    task automatic test_reset_mid_frame();
        logic [56:0] obs;
        int c1, g0, g1;
        reset_dut();
        drive(0, 1'b1, 16'h5000, 1'b0);
        drive(1, 1'b1, 16'h6000, 1'b1);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        obs = {bus.req0_ready, bus.req1_ready, bus.st_en, bus.st_din, bus.out0_en, bus.out0_data,
               bus.out1_en, bus.out1_data, bus.frame_done0, bus.frame_done1, busy, grant_id};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h, required 0", obs);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        c1 = cyc;
        fork
            send_frame(0, 1, 16'h7000, -1, 0, g0);
            send_frame(1, 1, 16'h8000, -1, 0, g1);
        join
        vectors++;
        if (g0 !== c1 + 1 || g1 !== c1 + 3) begin
            miscompares++;
            $display("FAIL midreset_regrant: got grants %0d %0d, required %0d %0d", g0, g1, c1 + 1, c1 + 3);
        end
        drain("midreset");
    endtask

`ifdef ISP_ARB_STATS_EN
    task automatic test_stats();
        int g;
        reset_dut();
        cfg_en = 2'b10;
        for (int f = 0; f < 3; f++) send_frame(1, 2, 16'h9000 + 16'(f), -1, 0, g);
        drain("stats");
        vectors++;
        if (frame_cnt1 !== 16'd3 || frame_cnt0 !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_count: got cnt0 %0d cnt1 %0d, required 0 3", frame_cnt0, frame_cnt1);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        test_reset();
        test_single();
        test_round_robin(1'b0);
        test_round_robin(1'b1);
        test_cfg_en();
        test_gaps();
        test_reset_mid_frame();
`ifdef ISP_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
